// File: rtl/cpu_pkg.sv
// Shared CPU front-end types and constants: word widths, jump opcodes and fetch records.
package cpu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned INST_W = 32;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } fetch_entry_t;

  // One per outstanding memory read: the epoch it was issued in and its address.
  typedef struct packed {
    logic            epoch;
    logic [XLEN-1:0] pc;
  } fetch_tag_t;

  function automatic logic is_jump(input logic [5:0] opcode);
    return (opcode == OP_J) || (opcode == OP_JAL);
  endfunction

  // Pseudo-direct target: region bits come from the address of the delay slot.
  function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc,
                                                   input logic [25:0]     index);
    logic [XLEN-1:0] pc_plus4;
    pc_plus4 = pc + 32'd4;
    return (pc_plus4 & 32'hF000_0000) | {4'b0000, index, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response bus between fetch (master) and memory (slave).
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [XLEN-1:0]   imem_req_addr;
  logic              imem_resp_valid;
  logic [INST_W-1:0] imem_resp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_resp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_resp_data
  );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with flush and occupancy count; used for both the
// output instruction buffer and the in-flight tag queue.
module fetch_fifo #(
  parameter int unsigned Width = 32,
  parameter int unsigned Depth = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [Width-1:0]         push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output logic [Width-1:0]         pop_data_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             empty, full, push_ok, pop_ok;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CntW'(Depth));
    pop_ok   = pop_i && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    push_ok  = push_i && (!full || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word reads, drops wrong-path
// responses by epoch. Define FETCH_JUMP_PREDECODE_EN to redirect early on J/JAL words.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  fetch_unit_if.master      imem,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_pc_plus4
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic            run_q, run_d;
  logic            epoch_q, epoch_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;

  logic            req_fire, resp_good, resp_dec, out_pop;
  logic [CW:0]     credit_used;
  logic [CW-1:0]   fifo_count, tag_count;
  fetch_tag_t      tag_head, tag_push;
  fetch_entry_t    fifo_head, fifo_push;
`ifdef FETCH_JUMP_PREDECODE_EN
  logic            jump_redirect;
`endif

  always_comb begin
    run_d     = 1'b1;
    out_valid = (fifo_count != '0);
    out_pop   = out_valid && out_ready && !redirect_valid;
    // A pop this cycle frees a slot, which keeps one-per-cycle streaming at latency 1.
    credit_used = (CW+1)'(inflight_q) + (CW+1)'(fifo_count) - (CW+1)'(out_pop);
    imem.imem_req_valid = run_q && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    imem.imem_req_addr  = fetch_pc_q;
    req_fire = imem.imem_req_valid && imem.imem_req_ready;

    tag_push  = '{epoch: epoch_q, pc: fetch_pc_q};
    resp_good = imem.imem_resp_valid && (tag_head.epoch == epoch_q) && !redirect_valid;
    resp_dec  = imem.imem_resp_valid && (inflight_q != '0);
    fifo_push = '{inst: imem.imem_resp_data, pc: tag_head.pc};

    fetch_pc_d = fetch_pc_q;
    epoch_d    = epoch_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
`ifdef FETCH_JUMP_PREDECODE_EN
    // The jump itself stays in the FIFO; only younger fetches go stale.
    jump_redirect = resp_good && is_jump(imem.imem_resp_data[31:26]);
    if (jump_redirect) begin
      fetch_pc_d = jump_target(tag_head.pc, imem.imem_resp_data[25:0]);
      epoch_d    = ~epoch_q;
    end
`endif
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~32'h0000_0003;
      epoch_d    = ~epoch_q;
    end
    inflight_d = inflight_q + CW'(req_fire) - CW'(resp_dec);

    out_inst     = out_valid ? fifo_head.inst : '0;
    out_pc       = out_valid ? fifo_head.pc : '0;
    out_pc_plus4 = out_valid ? fifo_head.pc + 32'd4 : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q      <= 1'b0;
      epoch_q    <= 1'b0;
      fetch_pc_q <= RESET_PC;
      inflight_q <= '0;
    end else begin
      run_q      <= run_d;
      epoch_q    <= epoch_d;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .Width ($bits(fetch_entry_t)),
    .Depth (DEPTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (resp_good),
    .push_data_i (fifo_push),
    .pop_i       (out_pop),
    .flush_i     (redirect_valid),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count)
  );

  // Never flushed: stale fetches must still retire their tag when they return.
  fetch_fifo #(
    .Width ($bits(fetch_tag_t)),
    .Depth (DEPTH)
  ) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (req_fire),
    .push_data_i (tag_push),
    .pop_i       (imem.imem_resp_valid),
    .flush_i     (1'b0),
    .pop_data_o  (tag_head),
    .count_o     (tag_count)
  );

  assert property (@(posedge clk) disable iff (rst) imem.imem_resp_valid |-> inflight_q != '0);
  assert property (@(posedge clk) disable iff (rst) tag_count == inflight_q);
  assert property (@(posedge clk) disable iff (rst)
                   (CW+1)'(inflight_q) + (CW+1)'(fifo_count) <= (CW+1)'(DEPTH));

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder/datapath top.
- Owns the architectural program counter and issues in-order word reads to instruction memory.
- Buffers returned words and hands {inst, pc, pc+4} to decode over a valid/ready handshake.
- Accepts branch/jump redirects from downstream and discards wrong-path fetches using an epoch tag.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0).
- DEPTH, 2, output FIFO entries; also the maximum number of in-flight plus buffered fetches (credit limit, power of 2, ≥2).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_req_addr  out  32  word-aligned fetch address.
- imem_resp_valid  in  1  read data valid; in order, no backpressure, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  taken branch/jump from downstream.
- redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode consumes this cycle.
- out_inst  out  32  instruction word.
- out_pc  out  32  address of out_inst.
- out_pc_plus4  out  32  out_pc + 4, modulo 2^32.

Behaviour:
- Reset (async assert): fetch_pc = RESET_PC, epoch = 0, inflight = 0, FIFO empty, imem_req_valid = 0, out_valid = 0, all data outputs 0.
- Issue: imem_req_valid = 1 when (inflight + fifo_count) < DEPTH and no redirect this cycle. imem_req_addr = fetch_pc.
  - On acceptance (valid & ready): fetch_pc += 4 (wraps 32'hFFFF_FFFC → 0), inflight++.
  - The current epoch is pushed into a DEPTH-entry tag queue.
- First request is presented the first clock after rst deasserts.
- Response: pop the tag and decrement inflight.
  - If tag == epoch, push {data, pc} into the FIFO; the pc is also tracked in the tag queue.
  - If tag != epoch, discard the response silently; it still returns its credit.
- Output: registered FIFO.
  - Response in cycle N → out_valid in cycle N+1 at the earliest.
  - Pop on out_valid & out_ready. Outputs hold stable while out_valid & !out_ready.
  - Push and pop in the same cycle are both allowed when the FIFO is full or empty.
- Redirect (highest priority):
  - Next cycle: fetch_pc = {redirect_pc[31:2], 2'b00}, epoch toggles, FIFO flushed, out_valid = 0.
  - A response arriving in the redirect cycle is discarded.
  - A request accepted in the redirect cycle is tagged with the old epoch, so it becomes stale.
  - A redirect during an in-flight fetch never stalls issue beyond the credit limit.
  - Back-to-back redirects are allowed; the last one wins.
- The credit counter never exceeds DEPTH and never underflows. A response with inflight == 0 is a protocol error; flag it with an assertion.
- Simultaneous redirect and out_ready: the pop is ignored, because the flush dominates.

Optional Feature:
- Macro: FETCH_JUMP_PREDECODE_EN.
- Enabled:
  - A response with matching epoch whose opcode inst[31:26] is 6'b000010 or 6'b000011 is still pushed into the FIFO.
  - In the same cycle, an internal redirect occurs to {pc_plus4[31:28], inst[25:0], 2'b00}, with epoch toggle.
  - The FIFO is not flushed, since older entries are valid.
  - An external redirect in the same cycle takes priority.
- Disabled: J/JAL are treated as ordinary words, and the redirect comes only from the port.

Decomposition:
- Shared package cpu_pkg:
  - XLEN = 32 and INST_W = 32.
  - OP_J = 6'b000010 and OP_JAL = 6'b000011.
  - typedef fetch_entry_t {inst, pc}.
- One natural sub-module: fetch_fifo, a parameterised DEPTH FIFO with push/pop/flush and count output. It is reused for the tag queue with a narrower width.

Test Plan:
- Reset with RESET_PC = 0x100, memory latency 1, out_ready = 1 → requests 0x100, 0x104, 0x108; outputs carry matching pc, pc_plus4 = pc + 4, and sustain 1 instruction per cycle.
- Hold out_ready = 0 → at most DEPTH = 2 requests issued, then imem_req_valid = 0; out_inst/out_pc stable; the release drains in order with no loss.
- Two requests in flight (0x200, 0x204), then redirect_pc = 0x403 → both stale responses dropped; next request 0x400; first out_pc = 0x400.
- fetch_pc = 0xFFFF_FFFC → the next request is 0x0000_0000; out_pc_plus4 = 0x0000_0000 for the first.
- Assert rst mid-stream with one response pending → all outputs 0 immediately; after release, fetch restarts at RESET_PC with inflight = 0.
- With FETCH_JUMP_PREDECODE_EN, word 0x0800_0040 at pc 0x1000_0000 → the J is output, the next request is 0x1000_0100, and the word at 0x1000_0004 is discarded.
